pdm_pixel_packer: RTL and testbench

Downstream neighbour of the pixel painter in the LED panel pipeline. It takes the painter's registered `rgb24` stream, with coordinates and subframe realigned to the painter's one-cycle latency. Each 8-bit channel becomes a 1-bit pulse-density sample by comparing it against a bit-reversed subframe threshold. Upper-half (y < 32) and lower-half (y ≥ 32) pixels of the same column and row are paired into the 6-bit HUB75 data word consumed by the panel shifter.

---
 rtl/pdm_pixel_packer_pkg.sv | 24 ++
 rtl/pdm_pixel_packer_compare.sv | 24 ++
 rtl/pdm_pixel_packer.sv | 121 ++++++++++++
 tb/tb_pdm_pixel_packer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pixel_packer_pkg.sv
// Shared HUB75 constants for the pixel packer and panel shifter.
// Bit positions of out_rgb6, half-select bit of y, and the pairing action set.
package pdm_pixel_packer_pkg;

    localparam int unsigned SUBFRAME_BITS_DEFAULT = 8;
    localparam int unsigned CHAN_BITS             = 8;
    localparam int unsigned HALF_BIT              = 5;

    localparam int unsigned HUB_R0 = 0;
    localparam int unsigned HUB_G0 = 1;
    localparam int unsigned HUB_B0 = 2;
    localparam int unsigned HUB_R1 = 3;
    localparam int unsigned HUB_G1 = 4;
    localparam int unsigned HUB_B1 = 5;

    typedef enum logic [2:0] {
        PAIR_IDLE,
        PAIR_CAPTURE,
        PAIR_ORPHAN,
        PAIR_EMIT,
        PAIR_MISMATCH
    } pair_action_e;

endpackage

// File: rtl/pdm_pixel_packer_compare.sv
// One-channel PDM slicer: channel lit when strictly above the bit-reversed subframe.
import pdm_pixel_packer_pkg::*;

module pdm_compare #(
    parameter int unsigned WIDTH = SUBFRAME_BITS_DEFAULT
) (
    input  logic [WIDTH-1:0] channel,
    input  logic [WIDTH-1:0] subframe,
    output logic             lit
);

    logic [WIDTH-1:0] threshold;

    // Bit reversal spreads the v lit subframes evenly over the 2^WIDTH period.
    always_comb begin
        threshold = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            threshold[i] = subframe[WIDTH-1-i];
        end
    end

    assign lit = (channel > threshold);

endmodule

// File: rtl/pdm_pixel_packer.sv
// Converts rgb24 pixels to PDM bits and pairs upper/lower halves into HUB75 words.
// Stage 1 registers the compare result; stage 2 holds one upper entry for pairing.
import pdm_pixel_packer_pkg::*;

module pdm_pixel_packer #(
    parameter int unsigned SUBFRAME_BITS = SUBFRAME_BITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [5:0]               in_x,
    input  logic [5:0]               in_y,
    input  logic [SUBFRAME_BITS-1:0] in_subframe,
    input  logic [23:0]              in_rgb24,
    output logic                     out_valid,
    output logic [5:0]               out_rgb6,
    output logic [5:0]               out_x,
    output logic [4:0]               out_row,
    output logic                     pair_error
);

    logic [2:0] lit;

    pdm_compare #(.WIDTH(SUBFRAME_BITS)) u_cmp_r (
        .channel  (in_rgb24[CHAN_BITS-1:0]),
        .subframe (in_subframe),
        .lit      (lit[0])
    );

    pdm_compare #(.WIDTH(SUBFRAME_BITS)) u_cmp_g (
        .channel  (in_rgb24[2*CHAN_BITS-1:CHAN_BITS]),
        .subframe (in_subframe),
        .lit      (lit[1])
    );

    pdm_compare #(.WIDTH(SUBFRAME_BITS)) u_cmp_b (
        .channel  (in_rgb24[3*CHAN_BITS-1:2*CHAN_BITS]),
        .subframe (in_subframe),
        .lit      (lit[2])
    );

    logic       s1_valid;
    logic [2:0] s1_bits;
    logic [5:0] s1_x;
    logic [5:0] s1_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_bits  <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_bits  <= lit;
            s1_x     <= in_x;
            s1_y     <= in_y;
        end
    end

    logic         hold_full;
    logic [2:0]   hold_bits;
    logic [5:0]   hold_x;
    logic [4:0]   hold_row;
    pair_action_e action;

    always_comb begin
        action = PAIR_IDLE;
        if (s1_valid) begin
            if (!s1_y[HALF_BIT]) begin
                action = hold_full ? PAIR_ORPHAN : PAIR_CAPTURE;
            end else if (hold_full && hold_x == s1_x && hold_row == s1_y[4:0]) begin
                action = PAIR_EMIT;
            end else begin
                action = PAIR_MISMATCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full  <= 1'b0;
            hold_bits  <= '0;
            hold_x     <= '0;
            hold_row   <= '0;
            out_valid  <= 1'b0;
            pair_error <= 1'b0;
            out_rgb6   <= '0;
            out_x      <= '0;
            out_row    <= '0;
        end else begin
            out_valid  <= 1'b0;
            pair_error <= 1'b0;
            case (action)
                PAIR_CAPTURE, PAIR_ORPHAN: begin
                    hold_full  <= 1'b1;
                    hold_bits  <= s1_bits;
                    hold_x     <= s1_x;
                    hold_row   <= s1_y[4:0];
                    pair_error <= (action == PAIR_ORPHAN);
                end
                PAIR_EMIT, PAIR_MISMATCH: begin
                    hold_full        <= 1'b0;
                    out_valid        <= 1'b1;
                    pair_error       <= (action == PAIR_MISMATCH);
                    out_x            <= s1_x;
                    out_row          <= s1_y[4:0];
                    out_rgb6[HUB_R1] <= s1_bits[0];
                    out_rgb6[HUB_G1] <= s1_bits[1];
                    out_rgb6[HUB_B1] <= s1_bits[2];
                    // A lower pixel without a matching upper is emitted with a dark upper half.
                    out_rgb6[HUB_R0] <= (action == PAIR_EMIT) && hold_bits[0];
                    out_rgb6[HUB_G0] <= (action == PAIR_EMIT) && hold_bits[1];
                    out_rgb6[HUB_B0] <= (action == PAIR_EMIT) && hold_bits[2];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_pixel_packer.sv
// Scoreboard bench for pdm_pixel_packer: a reference model queues expected events
// (out_valid words and bare pair_error pulses) with due cycles; a monitor pops and compares.
module tb_pdm_pixel_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [5:0]  in_x;
    logic [5:0]  in_y;
    logic [7:0]  in_subframe;
    logic [23:0] in_rgb24;
    logic        out_valid;
    logic [5:0]  out_rgb6;
    logic [5:0]  out_x;
    logic [4:0]  out_row;
    logic        pair_error;

    pdm_pixel_packer #(.SUBFRAME_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_subframe (in_subframe),
        .in_rgb24    (in_rgb24),
        .out_valid   (out_valid),
        .out_rgb6    (out_rgb6),
        .out_x       (out_x),
        .out_row     (out_row),
        .pair_error  (pair_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic       ov;
        logic       pe;
        logic [5:0] rgb;
        logic [5:0] x;
        logic [4:0] row;
    } event_t;

    event_t sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     ov_count = 0;
    int     r_cnt = 0, g_cnt = 0, b_cnt = 0;

    logic       m_full;
    logic [2:0] m_bits;
    logic [5:0] m_x;
    logic [4:0] m_row;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every out_valid or pair_error pulse must match the oldest queued event.
    initial begin
        event_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1 || pair_error === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got ov=%b pe=%b rgb=%b x=%0d row=%0d, required no event",
                             cyc, out_valid, pair_error, out_rgb6, out_x, out_row);
                end else begin
                    e = sb.pop_front();
                    if (cyc !== e.due || out_valid !== e.ov || pair_error !== e.pe) begin
                        errors++;
                        $display("FAIL event_timing got cyc=%0d ov=%b pe=%b, required cyc=%0d ov=%b pe=%b",
                                 cyc, out_valid, pair_error, e.due, e.ov, e.pe);
                    end
                    if (e.ov) begin
                        checks++;
                        if (out_rgb6 !== e.rgb || out_x !== e.x || out_row !== e.row) begin
                            errors++;
                            $display("FAIL out_word got rgb=%b x=%0d row=%0d, required rgb=%b x=%0d row=%0d",
                                     out_rgb6, out_x, out_row, e.rgb, e.x, e.row);
                        end
                    end
                end
                if (out_valid === 1'b1) begin
                    ov_count++;
                    r_cnt += int'(out_rgb6[3]);
                    g_cnt += int'(out_rgb6[4]);
                    b_cnt += int'(out_rgb6[5]);
                end
            end
        end
    end

    function automatic logic [2:0] model_bits(input logic [23:0] rgb, input logic [7:0] sf);
        logic [7:0] thr;
        thr = {<<{sf}};
        return {rgb[23:16] > thr, rgb[15:8] > thr, rgb[7:0] > thr};
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Drives one pixel for the coming edge and queues whatever the model expects from it.
    task automatic drive_pix(input logic [5:0] x, input logic [5:0] y,
                             input logic [7:0] sf, input logic [23:0] rgb);
        event_t     e;
        logic [2:0] bits;
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        in_x        = x;
        in_y        = y;
        in_subframe = sf;
        in_rgb24    = rgb;
        bits        = model_bits(rgb, sf);
        e.due = cyc + 2;
        e.x   = x;
        e.row = y[4:0];
        if (!y[5]) begin
            if (m_full) begin
                e.ov = 1'b0; e.pe = 1'b1; e.rgb = '0;
                sb.push_back(e);
            end
            m_full = 1'b1; m_bits = bits; m_x = x; m_row = y[4:0];
        end else begin
            e.ov = 1'b1;
            if (m_full && m_x == x && m_row == y[4:0]) begin
                e.pe = 1'b0; e.rgb = {bits, m_bits};
            end else begin
                e.pe = 1'b1; e.rgb = {bits, 3'b000};
            end
            m_full = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        idle();
        while (sb.size() != 0 && n < 20) begin
            idle();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending events, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_full = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pair_error !== 1'b0 || out_rgb6 !== 6'd0 ||
            out_x !== 6'd0 || out_row !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got ov=%b pe=%b rgb=%b x=%0d row=%0d, required all 0",
                     out_valid, pair_error, out_rgb6, out_x, out_row);
        end
    endtask

    task automatic test_threshold_sweep();
        r_cnt = 0; g_cnt = 0; b_cnt = 0;
        for (int s = 0; s < 256; s++) begin
            drive_pix(6'd9, 6'd40, 8'(s), {8'd0, 8'd255, 8'd128});
        end
        drain("sweep");
        checks++;
        if (r_cnt != 128 || g_cnt != 255 || b_cnt != 0) begin
            errors++;
            $display("FAIL sweep_counts got r=%0d g=%0d b=%0d, required r=128 g=255 b=0",
                     r_cnt, g_cnt, b_cnt);
        end
    endtask

    task automatic test_normal_pair();
        drive_pix(6'd5, 6'd3, 8'd0, 24'hFFFFFF);
        drive_pix(6'd5, 6'd35, 8'd0, 24'h000000);
        drain("normal");
    endtask

    task automatic test_mismatch();
        drive_pix(6'd5, 6'd3, 8'd0, 24'hFFFFFF);
        drive_pix(6'd6, 6'd35, 8'd0, 24'hFFFFFF);
        // Hold must now be empty, so a lower that would have matched still errors.
        drive_pix(6'd5, 6'd35, 8'd0, 24'hFFFFFF);
        drain("mismatch");
    endtask

    task automatic test_orphan_upper();
        drive_pix(6'd1, 6'd0, 8'd77, 24'h123456);
        drive_pix(6'd2, 6'd0, 8'd3, 24'h80C040);
        idle();
        drive_pix(6'd2, 6'd32, 8'd3, 24'h40FF10);
        drain("orphan");
    endtask

    task automatic test_reset_mid_pair();
        drive_pix(6'd12, 6'd4, 8'd0, 24'hFFFFFF);
        test_reset();
        drive_pix(6'd12, 6'd36, 8'd0, 24'hFFFFFF);
        drain("reset_mid_pair");
    endtask

    task automatic test_back_to_back();
        int start_ov;
        start_ov = ov_count;
        for (int c = 0; c < 32; c++) begin
            drive_pix(6'(c), 6'd7, 8'(c * 8 + 1), {8'(c * 3), 8'(c * 5), 8'(c * 7)});
            drive_pix(6'(c), 6'd39, 8'(c * 8 + 1), {8'(255 - c), 8'(c * 2), 8'(128 + c)});
        end
        drain("back_to_back");
        checks++;
        if (ov_count - start_ov != 32) begin
            errors++;
            $display("FAIL back_to_back_strobes got %0d, required 32", ov_count - start_ov);
        end
    endtask

    task automatic test_idle_gap_pair();
        drive_pix(6'd20, 6'd10, 8'd200, 24'hA0B0C0);
        idle(); idle(); idle();
        drive_pix(6'd20, 6'd42, 8'd200, 24'h0F0F0F);
        drain("idle_gap");
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        in_subframe = '0;
        in_rgb24 = '0;
        m_full = 1'b0;
        m_bits = '0;
        m_x = '0;
        m_row = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_threshold_sweep();
        test_normal_pair();
        test_mismatch();
        test_orphan_upper();
        test_reset_mid_pair();
        test_back_to_back();
        test_idle_gap_pair();
        repeat (3) idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got no finish, required finish");
        $fatal(1);
    end

endmodule
